// File: rtl/keypad_matrix_emu_if.sv
// Keypad matrix emulator bus: column-scan lines plus the key-press command handshake.
// The master modport is the scanner/test controller side, slave is the emulator.
interface keypad_matrix_emu_if #(
    parameter int HOLD_W = 24
);
    logic [3:0]        iCOL;
    logic [3:0]        oROW;
    logic              iKEY_VALID;
    logic              oKEY_READY;
    logic [3:0]        iKEY_NUM;
    logic [HOLD_W-1:0] iHOLD;
    logic              oBUSY;
    logic [15:0]       oPRESSED;
    logic              oDONE;

    modport master (
        output iCOL,
        output iKEY_VALID,
        output iKEY_NUM,
        output iHOLD,
        input  oROW,
        input  oKEY_READY,
        input  oBUSY,
        input  oPRESSED,
        input  oDONE
    );

    modport slave (
        input  iCOL,
        input  iKEY_VALID,
        input  iKEY_NUM,
        input  iHOLD,
        output oROW,
        output oKEY_READY,
        output oBUSY,
        output oPRESSED,
        output oDONE
    );
endinterface

// File: rtl/keypad_matrix_emu.sv
// 4x4 key-matrix emulator: answers a column scanner with row sense for one
// emulated contact that is pressed on command for a programmed hold time.
// Build option KEYPAD_EMU_BOUNCE_EN adds LFSR-driven contact bounce phases
// before and after the stable-closed hold; without it the FSM is IDLE -> HOLD -> IDLE.
module keypad_matrix_emu #(
    parameter int BOUNCE_CYCLES = 64,
    parameter int HOLD_W        = 24
) (
    input  logic               iclk,
    input  logic               irest,
    keypad_matrix_emu_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        P_BOUNCE = 2'd1,
        HOLD     = 2'd2,
        R_BOUNCE = 2'd3
    } state_t;

    // A bounce phase of zero cycles has no meaning; stop elaboration early.
    if (BOUNCE_CYCLES < 1) begin : g_bad_bounce
        $error("keypad_matrix_emu: BOUNCE_CYCLES must be >= 1");
    end

    state_t            state;
    state_t            state_next;
    logic [3:0]        key_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic [HOLD_W-1:0] hold_load;
    logic              done_q;
    logic              done_next;
    logic              contact;
    logic              accept;
    logic [15:0]       pressed;
    logic [3:0]        row_q;

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int BW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam logic [BW-1:0] B_LAST = BW'(BOUNCE_CYCLES - 1);

    logic [15:0]   lfsr;
    logic [BW-1:0] bcnt;
    logic [BW-1:0] bcnt_next;
    logic          lfsr_step;
`endif

    // A zero hold request still gives one stable-closed cycle.
    assign hold_load = (bus.iHOLD == '0) ? HOLD_W'(1) : bus.iHOLD;
    assign accept    = (state == IDLE) && bus.iKEY_VALID;

    // Next-state, counter and contact decode for the press sequence.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        done_next     = 1'b0;
        contact       = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
        bcnt_next     = bcnt;
        lfsr_step     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    hold_cnt_next = hold_load;
`ifdef KEYPAD_EMU_BOUNCE_EN
                    bcnt_next  = '0;
                    state_next = P_BOUNCE;
`else
                    state_next = HOLD;
`endif
                end
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            P_BOUNCE: begin
                contact   = lfsr[0];
                lfsr_step = 1'b1;
                if (bcnt == B_LAST) begin
                    bcnt_next  = '0;
                    state_next = HOLD;
                end else begin
                    bcnt_next = bcnt + 1'b1;
                end
            end
`endif
            HOLD: begin
                contact = 1'b1;
                if (hold_cnt <= HOLD_W'(1)) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                    state_next = R_BOUNCE;
`else
                    state_next = IDLE;
                    done_next  = 1'b1;
`endif
                end else begin
                    hold_cnt_next = hold_cnt - 1'b1;
                end
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            R_BOUNCE: begin
                contact   = lfsr[0];
                lfsr_step = 1'b1;
                if (bcnt == B_LAST) begin
                    bcnt_next  = '0;
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    bcnt_next = bcnt + 1'b1;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sequence state, latched command and completion pulse.
    always_ff @(posedge iclk) begin
        if (irest) begin
            state    <= IDLE;
            key_q    <= '0;
            hold_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
            done_q   <= done_next;
            if (accept) begin
                key_q <= bus.iKEY_NUM;
            end
        end
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    // Bounce phase counter and the Fibonacci LFSR (taps 16,14,13,11) that
    // produces the chattering contact; it only moves while bouncing.
    always_ff @(posedge iclk) begin
        if (irest) begin
            bcnt <= '0;
            lfsr <= 16'hACE1;
        end else begin
            bcnt <= bcnt_next;
            if (lfsr_step) begin
                lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            end
        end
    end
`endif

    // Only the latched key can ever close, so the vector is one-hot or zero.
    assign pressed = contact ? (16'(1) << key_q) : 16'h0000;

    // Registered row sense: a row pulls low when its closed contact sits on any selected column.
    always_ff @(posedge iclk) begin
        if (irest) begin
            row_q <= 4'hF;
        end else begin
            for (int r = 0; r < 4; r++) begin
                row_q[r] <= ~|(pressed[r*4 +: 4] & ~bus.iCOL);
            end
        end
    end

    assign bus.oROW       = row_q;
    assign bus.oPRESSED   = pressed;
    assign bus.oKEY_READY = (state == IDLE);
    assign bus.oBUSY      = (state != IDLE);
    assign bus.oDONE      = done_q;

endmodule
